// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor-control datapath: PI sequencer states,
// default fixed-point constants and a symmetric saturating clamp.
package motor_ctrl_pkg;

    localparam int DEFAULT_GAIN_SHIFT = 12;
    localparam int DEFAULT_LIMIT      = 32767;
    localparam int THETA_WIDTH        = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_PD,
        ST_MUL_ID,
        ST_MUL_PQ,
        ST_MUL_IQ,
        ST_SUM,
        ST_OUT
    } pi_state_t;

    // Wide enough for every intermediate in the datapath; callers truncate the result.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input logic signed [63:0] lim);
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

endpackage

// File: rtl/pi_mac_unit.sv
// Shared signed-by-unsigned multiplier with fixed-point arithmetic shift,
// one registered stage; the result follows its operands by one clock.
module pi_mac_unit #(
    parameter int A_WIDTH = 17,
    parameter int B_WIDTH = 16,
    parameter int SHIFT   = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [A_WIDTH-1:0]        a,
    input  logic        [B_WIDTH-1:0]        b,
    output logic signed [A_WIDTH+B_WIDTH:0]  result
);

    localparam int PW = A_WIDTH + B_WIDTH + 1;

    logic signed [B_WIDTH:0] b_ext;
    logic signed [PW-1:0]    prod;

    // Gain is unsigned: zero-extend so the signed multiply keeps it positive.
    assign b_ext = {1'b0, b};
    assign prod  = PW'(a) * PW'(b_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
        end else begin
            result <= prod >>> SHIFT;
        end
    end

endmodule

// File: rtl/dq_current_pi.sv
// Per-channel dq current PI controller: error -> P and I terms through one shared
// multiplier, clamped integrators per channel, packed {1, theta, vd, vq} for inverse Park.
module dq_current_pi
    import motor_ctrl_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 1,
    parameter int DATA_WIDTH    = 16,
    parameter int GAIN_WIDTH    = 16,
    parameter int GAIN_SHIFT    = DEFAULT_GAIN_SHIFT,
    parameter int LIMIT         = DEFAULT_LIMIT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [THETA_WIDTH+2*DATA_WIDTH-1:0]   in_data,
    input  logic [CHANNEL_WIDTH-1:0]              in_channel,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [DATA_WIDTH-1:0]          ref_d,
    input  logic signed [DATA_WIDTH-1:0]          ref_q,
    input  logic [GAIN_WIDTH-1:0]                 kp,
    input  logic [GAIN_WIDTH-1:0]                 ki,
    input  logic                                  clear,
    output logic [THETA_WIDTH+2*DATA_WIDTH:0]     out_data,
    output logic [CHANNEL_WIDTH-1:0]              out_channel,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int NCH = 2 ** CHANNEL_WIDTH;
    localparam int PW  = DATA_WIDTH + GAIN_WIDTH + 2;

    function automatic logic signed [DATA_WIDTH-1:0] clamp_dw(input logic signed [63:0] x);
        return DATA_WIDTH'(sat_signed(x, 64'(LIMIT)));
    endfunction

    pi_state_t                   state_reg;
    logic [THETA_WIDTH-1:0]      theta_reg;
    logic [CHANNEL_WIDTH-1:0]    ch_reg;
    logic [GAIN_WIDTH-1:0]       kp_reg;
    logic [GAIN_WIDTH-1:0]       ki_reg;
    logic signed [DATA_WIDTH-1:0] e_d_reg;
    logic signed [DATA_WIDTH-1:0] e_q_reg;
    logic signed [PW-1:0]        p_d_reg;
    logic signed [PW-1:0]        p_q_reg;

    logic signed [DATA_WIDTH-1:0] integ_d [NCH];
    logic signed [DATA_WIDTH-1:0] integ_q [NCH];

    logic [THETA_WIDTH-1:0]       in_theta;
    logic signed [DATA_WIDTH-1:0] in_id;
    logic signed [DATA_WIDTH-1:0] in_iq;
    logic signed [DATA_WIDTH:0]   diff_d;
    logic signed [DATA_WIDTH:0]   diff_q;

    logic signed [DATA_WIDTH-1:0] mac_a;
    logic [GAIN_WIDTH-1:0]        mac_b;
    logic signed [PW-1:0]         mac_result;

    logic signed [DATA_WIDTH-1:0] integ_d_new;
    logic signed [DATA_WIDTH-1:0] integ_q_new;
    logic signed [DATA_WIDTH-1:0] integ_d_use;
    logic signed [DATA_WIDTH-1:0] integ_q_use;
    logic signed [DATA_WIDTH-1:0] vd_new;
    logic signed [DATA_WIDTH-1:0] vq_new;

    assign in_theta = in_data[THETA_WIDTH+2*DATA_WIDTH-1 -: THETA_WIDTH];
    assign in_id    = in_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign in_iq    = in_data[DATA_WIDTH-1:0];
    assign diff_d   = (DATA_WIDTH+1)'(ref_d) - (DATA_WIDTH+1)'(in_id);
    assign diff_q   = (DATA_WIDTH+1)'(ref_q) - (DATA_WIDTH+1)'(in_iq);

    assign in_ready = reset && (state_reg == ST_IDLE);

    // Operand schedule: each product lands in mac_result one state after it is issued.
    always_comb begin
        mac_a = e_d_reg;
        mac_b = kp_reg;
        case (state_reg)
            ST_MUL_ID: mac_b = ki_reg;
            ST_MUL_PQ: mac_a = e_q_reg;
            ST_MUL_IQ: begin
                mac_a = e_q_reg;
                mac_b = ki_reg;
            end
            default: ;
        endcase
    end

    pi_mac_unit #(
        .A_WIDTH (DATA_WIDTH + 1),
        .B_WIDTH (GAIN_WIDTH),
        .SHIFT   (GAIN_SHIFT)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .a      ((DATA_WIDTH+1)'(mac_a)),
        .b      (mac_b),
        .result (mac_result)
    );

    assign integ_d_new = clamp_dw(64'(integ_d[ch_reg]) + 64'(mac_result));
    assign integ_q_new = clamp_dw(64'(integ_q[ch_reg]) + 64'(mac_result));

    // A clear landing on the SUM edge zeroes the integrators, so the output sees zero too.
    assign integ_d_use = clear ? '0 : integ_d[ch_reg];
    assign integ_q_use = clear ? '0 : integ_q_new;
    assign vd_new      = clamp_dw(64'(p_d_reg) + 64'(integ_d_use));
    assign vq_new      = clamp_dw(64'(p_q_reg) + 64'(integ_q_use));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                integ_d[i] <= '0;
                integ_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                integ_d[i] <= '0;
                integ_q[i] <= '0;
            end
        end else begin
            if (state_reg == ST_MUL_PQ) begin
                integ_d[ch_reg] <= integ_d_new;
            end
            if (state_reg == ST_SUM) begin
                integ_q[ch_reg] <= integ_q_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            theta_reg   <= '0;
            ch_reg      <= '0;
            kp_reg      <= '0;
            ki_reg      <= '0;
            e_d_reg     <= '0;
            e_q_reg     <= '0;
            p_d_reg     <= '0;
            p_q_reg     <= '0;
            out_data    <= '0;
            out_channel <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        theta_reg <= in_theta;
                        ch_reg    <= in_channel;
                        kp_reg    <= kp;
                        ki_reg    <= ki;
                        e_d_reg   <= clamp_dw(64'(diff_d));
                        e_q_reg   <= clamp_dw(64'(diff_q));
                        state_reg <= ST_MUL_PD;
                    end
                end
                ST_MUL_PD: state_reg <= ST_MUL_ID;
                ST_MUL_ID: begin
                    p_d_reg   <= mac_result;
                    state_reg <= ST_MUL_PQ;
                end
                ST_MUL_PQ: state_reg <= ST_MUL_IQ;
                ST_MUL_IQ: begin
                    p_q_reg   <= mac_result;
                    state_reg <= ST_SUM;
                end
                ST_SUM: begin
                    out_data    <= {1'b1, theta_reg, vd_new, vq_new};
                    out_channel <= ch_reg;
                    out_valid   <= 1'b1;
                    state_reg   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
